comp_page_dispatcher: RTL
=========================

Name: comp_page_dispatcher

Overview:
- Splits an incoming host data stream into fixed-size pages.
- Dispatches each whole page to one of N_CORES compression cores, chosen round-robin, skipping busy cores.
- Emits a one-cycle page descriptor per page (core id, byte count, sequence number) for the downstream reorder/writeback logic.
- Sits between the Coyote host stream and the compression core array; generalises the fixed 4-core / 8 KiB page arrangement to parametrised core count, data width and page size, and adds short-final-page handling.

Parameters:
- DATA_BITS, 512, stream width in bits; byte-multiple, ≥ 64.
- N_CORES, 4, number of compression cores; 1..16.
- PAGE_SIZE, 8192, page size in bytes; multiple of DATA_BITS/8.
- SEQ_BITS, 32, width of the page sequence counter.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous reset, active-high.
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  input beat ready.
- s_tdata  in  DATA_BITS  input data.
- s_tkeep  in  DATA_BITS/8  byte enables; all ones except on a tlast beat, where contiguous from bit 0.
- s_tlast  in  1  end of transfer; closes the current page early.
- core_idle  in  N_CORES  core i can accept a new page.
- m_tvalid  out  N_CORES  per-core beat valid.
- m_tready  in  N_CORES  per-core beat ready.
- m_tdata  out  DATA_BITS  shared data to all cores.
- m_tkeep  out  DATA_BITS/8  shared byte enables.
- m_tlast  out  1  last beat of page; qualified by m_tvalid.
- desc_valid  out  1  one-cycle descriptor strobe.
- desc_core  out  clog2(N_CORES) (min 1)  core that received the page.
- desc_bytes  out  clog2(PAGE_SIZE)+1  page length in bytes.
- desc_seq  out  SEQ_BITS  page sequence number.

Behaviour:
- Derived constants: BEATS = PAGE_SIZE/(DATA_BITS/8); beat counter width clog2(BEATS)+1.
- Reset (async assert, sync to aclk on release):
  - State IDLE; rr pointer 0; beat count 0; seq 0.
  - s_tready = 0; m_tvalid = 0; desc_valid = 0; desc_core/desc_bytes/desc_seq = 0.
  - Reset mid-page abandons the page; no descriptor is issued.
- FSM states: IDLE, SELECT, STREAM, DONE.
- IDLE: s_tready = 0. Moves to SELECT once any core_idle bit is set.
- SELECT (one cycle):
  - Search starts at rr pointer; picks the first i with core_idle[i] = 1 (wrapping).
  - Latches sel = i and sets rr = (i+1) mod N_CORES.
  - Goes to STREAM. If core_idle has dropped to all-zero, returns to IDLE with no state change.
- STREAM (combinational pass-through):
  - m_tvalid[sel] = s_tvalid; all other m_tvalid bits 0.
  - s_tready = m_tready[sel]; m_tdata/m_tkeep = s_tdata/s_tkeep.
  - A beat transfers when s_tvalid && m_tready[sel]; each transfer increments the beat count.
  - m_tlast = s_tlast OR (count == BEATS-1).
  - On a transfer with m_tlast = 1, the byte count is latched as count*(DATA_BITS/8) + popcount(s_tkeep), and the FSM goes to DONE.
  - core_idle changes during STREAM are ignored.
- DONE (one cycle, s_tready = 0):
  - desc_valid = 1 with desc_core = sel, desc_bytes, desc_seq = seq.
  - Then seq increments (wraps modulo 2^SEQ_BITS), count clears, FSM returns to IDLE.
  - Descriptor fields hold until the next DONE.
- Latency: the first beat of a page is accepted no earlier than 2 cycles after entering IDLE with a core idle. Page gap is 3 cycles (DONE, IDLE, SELECT).
- s_tlast coinciding with count == BEATS-1 closes exactly one page; no empty page follows.
- s_tlast on the first beat produces a page of popcount(s_tkeep) bytes.
- A full page reports desc_bytes = PAGE_SIZE exactly; desc_bytes is never 0.
- Backpressure: while m_tready[sel] = 0, the beat is held and the count does not advance.

Test Plan:
- Defaults, stream 3×128 beats with all cores idle and ready → pages to cores 0, 1, 2; desc_bytes = 8192 each; desc_seq = 0, 1, 2; m_tlast on beats 127, 255, 383.
- core_idle = 4'b1010, rr = 0, 4 pages → cores 1, 3, 1, 3 in that order; m_tvalid bits for cores 0 and 2 never set.
- Stream of 200 beats, last beat s_tkeep = 0x0000_0000_0000_00FF → two pages; desc_bytes = 8192, then 71*64 + 8 = 4552; second page m_tlast on s_tlast beat.
- m_tready[sel] toggled at random 50% duty during a page → every beat delivered once in order; page still 128 beats, desc_bytes = 8192.
- areset asserted at beat 40 of a page, then 1 page streamed → no descriptor for the aborted page; next page goes to core 0 with desc_seq = 0.
- SEQ_BITS = 2, 5 pages → desc_seq = 0, 1, 2, 3, 0; with N_CORES = 1, all pages go to core 0 and desc_core = 0.

Source files
------------

// File: rtl/comp_page_dispatcher.sv
// comp_page_dispatcher
//   Cuts the incoming host stream into fixed-size pages and hands each whole
//   page to one compression core. Cores are picked round-robin, and cores that
//   are not idle are skipped. After the last beat of each page the block emits
//   a one-cycle descriptor (core, byte count, sequence number).
//
// Ports
//   aclk, areset        clock; asynchronous active-high reset
//   s_t*                host input stream (valid/ready/data/keep/last)
//   core_idle[N_CORES]  core i can take a new page
//   m_tvalid/m_tready   per-core handshake; data/keep/last are shared
//   desc_*              page descriptor; fields hold until the next page
module comp_page_dispatcher #(
  parameter int DATA_BITS = 512,
  parameter int N_CORES   = 4,
  parameter int PAGE_SIZE = 8192,
  parameter int SEQ_BITS  = 32,
  localparam int KEEP_BITS  = DATA_BITS / 8,
  localparam int CORE_BITS  = (N_CORES > 1) ? $clog2(N_CORES) : 1,
  localparam int BYTES_BITS = $clog2(PAGE_SIZE) + 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_BITS-1:0]  s_tdata,
  input  logic [KEEP_BITS-1:0]  s_tkeep,
  input  logic                  s_tlast,
  input  logic [N_CORES-1:0]    core_idle,
  output logic [N_CORES-1:0]    m_tvalid,
  input  logic [N_CORES-1:0]    m_tready,
  output logic [DATA_BITS-1:0]  m_tdata,
  output logic [KEEP_BITS-1:0]  m_tkeep,
  output logic                  m_tlast,
  output logic                  desc_valid,
  output logic [CORE_BITS-1:0]  desc_core,
  output logic [BYTES_BITS-1:0] desc_bytes,
  output logic [SEQ_BITS-1:0]   desc_seq
);

  localparam int BEATS    = PAGE_SIZE / KEEP_BITS;
  localparam int CNT_BITS = $clog2(BEATS) + 1;

  typedef enum logic [1:0] {IDLE, SELECT, STREAM, DONE} state_t;

  state_t                state_q, state_d;
  logic [CORE_BITS-1:0]  rr_q, sel_q;
  logic [CNT_BITS-1:0]   count_q;
  logic [SEQ_BITS-1:0]   seq_q;
  logic [BYTES_BITS-1:0] bytes_q;
  logic [CORE_BITS-1:0]  hold_core_q;
  logic [BYTES_BITS-1:0] hold_bytes_q;
  logic [SEQ_BITS-1:0]   hold_seq_q;

  logic                  found;
  logic [CORE_BITS-1:0]  pick, rr_next;
  logic [BYTES_BITS-1:0] keep_ones, page_bytes;
  logic                  at_end, xfer;
  int                    idx;

  // Round-robin search: first idle core at or after the rr pointer, wrapping.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    found   = 1'b0;
    pick    = '0;
    rr_next = '0;
    idx     = 0;
    for (int k = 0; k < N_CORES; k++) begin
      idx = (int'(rr_q) + k) % N_CORES;
      if (!found && core_idle[CORE_BITS'(idx)]) begin
        found   = 1'b1;
        pick    = CORE_BITS'(idx);
        rr_next = CORE_BITS'((idx + 1) % N_CORES);
      end
    end
  end

  // Byte length of the page if the current beat is its last one.
  always_comb begin
    keep_ones = '0;
    for (int b = 0; b < KEEP_BITS; b++) begin
      keep_ones = keep_ones + BYTES_BITS'(s_tkeep[b]);
    end
    page_bytes = BYTES_BITS'(count_q) * BYTES_BITS'(KEEP_BITS) + keep_ones;
  end

  // A page closes on host tlast or when it reaches its full size, whichever
  // comes first; both together still close a single page.
  assign at_end = s_tlast || (count_q == CNT_BITS'(BEATS - 1));
  assign xfer   = (state_q == STREAM) && s_tvalid && m_tready[sel_q];

  always_comb begin
    state_d    = state_q;
    s_tready   = 1'b0;
    m_tvalid   = '0;
    m_tlast    = 1'b0;
    desc_valid = 1'b0;
    case (state_q)
      IDLE:   if (|core_idle) state_d = SELECT;
      SELECT: state_d = found ? STREAM : IDLE;
      STREAM: begin
        m_tvalid[sel_q] = s_tvalid;
        s_tready        = m_tready[sel_q];
        m_tlast         = at_end;
        if (xfer && at_end) state_d = DONE;
      end
      DONE: begin
        desc_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_tdata = s_tdata;
  assign m_tkeep = s_tkeep;

  // The live page is shown during DONE; afterwards the held copy keeps the
  // descriptor stable until the next page completes.
  assign desc_core  = (state_q == DONE) ? sel_q   : hold_core_q;
  assign desc_bytes = (state_q == DONE) ? bytes_q : hold_bytes_q;
  assign desc_seq   = (state_q == DONE) ? seq_q   : hold_seq_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      sel_q        <= '0;
      count_q      <= '0;
      seq_q        <= '0;
      bytes_q      <= '0;
      hold_core_q  <= '0;
      hold_bytes_q <= '0;
      hold_seq_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q <= state_d;
      if (state_q == SELECT && found) begin
        sel_q <= pick;
        rr_q  <= rr_next;
      end
      if (xfer) begin
        count_q <= count_q + 1'b1;
        if (at_end) bytes_q <= page_bytes;
      end
      if (state_q == DONE) begin
        hold_core_q  <= sel_q;
        hold_bytes_q <= bytes_q;
        hold_seq_q   <= seq_q;
        seq_q        <= seq_q + 1'b1;
        count_q      <= '0;
      end
    end
  end

endmodule
